// File: rtl/dmem_beat_controller.sv
// Serialises a 128-bit core data request into four 32-bit SRAM beats.
// Optional DMEM_WRITE_SKIP_EN drops write beats whose lane strobes are zero.
module dmem_beat_controller #(
  parameter int READ_LATENCY = 1,
  parameter int MEM_ADDR_W   = 30
) (
  input  logic                  clock,
  input  logic                  async_reset,
  input  logic                  memory_transaction,
  input  logic                  mem_write,
  input  logic [31:0]           address,
  input  logic [127:0]          write_data_bus,
  input  logic [15:0]           byte_enablers,
  output logic [127:0]          read_data_bus,
  output logic                  data_ready,
  output logic                  mem_chip_select,
  output logic                  mem_write_enable,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [3:0]            mem_byte_enable,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                         state_q, state_d;
  logic                           we_q, we_d;
  logic [MEM_ADDR_W-1:0]          base_q, base_d;
  logic [127:0]                   wdata_q, wdata_d;
  logic [15:0]                    be_q, be_d;
  logic [3:0]                     pend_q, pend_d;
  logic [127:0]                   buf_q, buf_d;
  logic [127:0]                   rdata_q, rdata_d;
  logic [READ_LATENCY-1:0]        tv_q, tv_d;
  logic [READ_LATENCY-1:0][1:0]   tl_q, tl_d;
  logic [1:0]                     beat;
  logic [3:0]                     live;
  logic                           unused_addr;

  assign unused_addr = ^address[1:0];

`ifdef DMEM_WRITE_SKIP_EN
  always_comb begin
    live = 4'h0;
    for (int i = 0; i < 4; i++)
      live[i] = !mem_write || (|byte_enablers[4*i +: 4]);
  end
`else
  assign live = 4'hF;
`endif

  // Beats go out lowest pending lane first
  always_comb begin
    if (pend_q[0])      beat = 2'd0;
    else if (pend_q[1]) beat = 2'd1;
    else if (pend_q[2]) beat = 2'd2;
    else                beat = 2'd3;
  end

  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    base_d           = base_q;
    wdata_d          = wdata_q;
    be_d             = be_q;
    pend_d           = pend_q;
    buf_d            = buf_q;
    rdata_d          = rdata_q;
    read_data_bus    = rdata_q;
    data_ready       = 1'b0;
    mem_chip_select  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_byte_enable  = 4'h0;
    mem_write_data   = 32'h0;
    tv_d             = '0;
    tl_d             = '0;
    tl_d[0]          = beat;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tv_d[i] = tv_q[i-1];
      tl_d[i] = tl_q[i-1];
    end
    if (tv_q[READ_LATENCY-1])
      buf_d[{tl_q[READ_LATENCY-1], 5'b0} +: 32] = mem_read_data;

    unique case (state_q)
      IDLE: begin
        if (memory_transaction) begin
          we_d    = mem_write;
          base_d  = address[MEM_ADDR_W+1:2];
          wdata_d = write_data_bus;
          be_d    = byte_enablers;
          pend_d  = live;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (pend_q == 4'h0) begin
          state_d = DONE;
        end else begin
          mem_chip_select  = 1'b1;
          mem_write_enable = we_q;
          mem_address      = base_q + MEM_ADDR_W'(beat);
          mem_byte_enable  = we_q ? be_q[{beat, 2'b00} +: 4] : 4'hF;
          mem_write_data   = wdata_q[{beat, 5'b0} +: 32];
          tv_d[0]          = !we_q;
          pend_d           = pend_q & ~(4'b0001 << beat);
          if (pend_d == 4'h0)
            state_d = we_q ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (tv_q[READ_LATENCY-1] && tl_q[READ_LATENCY-1] == 2'd3)
          state_d = DONE;
      end
      DONE: begin
        data_ready = 1'b1;
        if (!we_q) begin
          read_data_bus = buf_q;
          rdata_d       = buf_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      pend_q  <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      tv_q    <= '0;
      tl_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      tv_q    <= tv_d;
      tl_q    <= tl_d;
    end
  end

endmodule

// File: tb/tb_dmem_beat_controller.sv
// Bench for dmem_beat_controller: READ_LATENCY 1 and 3 instances,
// SRAM model, beat and result scoreboards.
module tb_dmem_beat_controller;

`ifdef DMEM_WRITE_SKIP_EN
  localparam bit SK = 1'b1;
`else
  localparam bit SK = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         async_reset = 1'b1;
  logic         mt1 = 1'b0, mt3 = 1'b0, mem_write = 1'b0, sel = 1'b0;
  logic [31:0]  address = '0;
  logic [127:0] write_data_bus = '0;
  logic [15:0]  byte_enablers = '0;
  logic [127:0] rdb1, rdb3;
  logic         dr1, dr3, cs1, cs3, we1, we3;
  logic [29:0]  ma1, ma3;
  logic [3:0]   mbe1, mbe3;
  logic [31:0]  mwd1, mwd3, mrd1, mrd3;

  always #5 clock = ~clock;

  dmem_beat_controller #(.READ_LATENCY(1), .MEM_ADDR_W(30)) dut1 (
    .clock(clock), .async_reset(async_reset), .memory_transaction(mt1),
    .mem_write(mem_write), .address(address), .write_data_bus(write_data_bus),
    .byte_enablers(byte_enablers), .read_data_bus(rdb1), .data_ready(dr1),
    .mem_chip_select(cs1), .mem_write_enable(we1), .mem_address(ma1),
    .mem_byte_enable(mbe1), .mem_write_data(mwd1), .mem_read_data(mrd1));

  dmem_beat_controller #(.READ_LATENCY(3), .MEM_ADDR_W(30)) dut3 (
    .clock(clock), .async_reset(async_reset), .memory_transaction(mt3),
    .mem_write(mem_write), .address(address), .write_data_bus(write_data_bus),
    .byte_enablers(byte_enablers), .read_data_bus(rdb3), .data_ready(dr3),
    .mem_chip_select(cs3), .mem_write_enable(we3), .mem_address(ma3),
    .mem_byte_enable(mbe3), .mem_write_data(mwd3), .mem_read_data(mrd3));

  function automatic logic [31:0] init_word(input int i);
    logic [8:0] k;
    k = i[8:0];
    if (k >= 9'h40 && k <= 9'h43) return 32'h0000_00A0 + {23'd0, k} - 32'h40;
    return {16'h5A5A, 7'd0, k};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // SRAM model shared by both instances; only one is active at a time
  logic [31:0] mem [512];
  logic [31:0] p3 [3];
  logic        mem_init = 1'b0;

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else begin
      if (cs1 && we1) mem[ma1[8:0]] <= merge(mem[ma1[8:0]], mwd1, mbe1);
      if (cs3 && we3) mem[ma3[8:0]] <= merge(mem[ma3[8:0]], mwd3, mbe3);
    end
    mrd1  <= (cs1 && !we1) ? mem[ma1[8:0]] : 32'hBAD0_0001;
    p3[0] <= (cs3 && !we3) ? mem[ma3[8:0]] : 32'hBAD0_0003;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mrd3 = p3[2];

  typedef struct {
    logic [29:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } beat_t;

  typedef struct {
    logic         we;
    logic [127:0] rd;
    int           lat;
  } res_t;

  typedef struct {
    bit           s;
    bit           we;
    logic [31:0]  a;
    logic [127:0] wd;
    logic [15:0]  be;
    int           lat;
  } vec_t;

  beat_t        bq[$];
  res_t         rq[$];
  logic [31:0]  refm [512];
  logic [127:0] lr [2];
  int           checks = 0, errors = 0, drn = 0, ndone = 0;
  beat_t        mb;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!async_reset && (sel ? cs3 : cs1)) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_extra: got chip select at %0h, expected none",
                 sel ? ma3 : ma1);
      end else begin
        mb = bq.pop_front();
        chk("beat_addr", 128'(sel ? ma3 : ma1), 128'(mb.a));
        chk("beat_we", 128'(sel ? we3 : we1), 128'(mb.we));
        chk("beat_be", 128'(sel ? mbe3 : mbe1), 128'(mb.be));
        if (mb.we) chk("beat_wdata", 128'(sel ? mwd3 : mwd1), 128'(mb.wd));
      end
    end
    if (!async_reset && (dr1 || dr3)) drn++;
  end

  task automatic push_req(input bit we, input logic [31:0] a,
                          input logic [127:0] wd, input logic [15:0] be, input int lat);
    logic [29:0] base, wa;
    logic [3:0]  lb;
    res_t        r;
    base  = a[31:2];
    r.we  = we;
    r.lat = lat;
    r.rd  = '0;
    for (int i = 0; i < 4; i++) begin
      wa = base + 30'(i);
      lb = be[4*i +: 4];
      if (we) begin
        refm[wa[8:0]] = merge(refm[wa[8:0]], wd[32*i +: 32], lb);
        if (!(SK && lb == 4'h0)) bq.push_back('{wa, 1'b1, lb, wd[32*i +: 32]});
      end else begin
        r.rd[32*i +: 32] = refm[wa[8:0]];
        bq.push_back('{wa, 1'b0, 4'hF, 32'h0});
      end
    end
    rq.push_back(r);
  endtask

  task automatic do_req(input bit s, input bit we, input logic [31:0] a,
                        input logic [127:0] wd, input logic [15:0] be, input int lat,
                        input bit hold, input bit scr, input bit wdr);
    int   k;
    bit   seen;
    res_t r;
    @(posedge clock);
    @(negedge clock);
    sel = s;
    mem_write = we;
    address = a;
    write_data_bus = wd;
    byte_enablers = be;
    mt1 = !s;
    mt3 = s;
    push_req(we, a, wd, be, lat);
    k = 0;
    seen = 0;
    while (!seen && k < 40) begin
      @(posedge clock);
      @(negedge clock);
      k++;
      if (scr) begin
        mem_write = 1'($urandom);
        address = $urandom;
        write_data_bus = {$urandom, $urandom, $urandom, $urandom};
        byte_enablers = 16'($urandom);
      end
      if (wdr && k == 2) begin
        mt1 = 1'b0;
        mt3 = 1'b0;
      end
      if (s ? dr3 : dr1) begin
        seen = 1;
        ndone++;
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_extra: got data_ready with no request pending");
        end else begin
          r = rq.pop_front();
          chk("latency", 128'(k), 128'(r.lat));
          if (r.we) begin
            chk("rdata_hold", s ? rdb3 : rdb1, lr[s]);
          end else begin
            chk("rdata", s ? rdb3 : rdb1, r.rd);
            lr[s] = r.rd;
          end
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no data_ready within 40 cycles for addr %0h", a);
    end
    if (!hold) begin
      mt1 = 1'b0;
      mt3 = 1'b0;
    end
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{0, 0, 32'h100, '0, 16'h0000, 6};
    tbl[1] = '{0, 1, 32'h200, {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF},
               16'h000F, SK ? 2 : 5};
    tbl[2] = '{0, 0, 32'h200, '0, 16'h0000, 6};
    tbl[3] = '{0, 1, 32'h300, {32'hC3C3_0303, 32'hC2C2_0202, 32'hC1C1_0101, 32'hC0C0_0000},
               16'hFFFF, 5};
    tbl[4] = '{0, 1, 32'h300, {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444},
               16'h0F30, SK ? 3 : 5};
    tbl[5] = '{0, 0, 32'h300, '0, 16'h0000, 6};
    tbl[6] = '{0, 1, 32'h400, {4{32'hFFFF_FFFF}}, 16'h0000, SK ? 2 : 5};
    tbl[7] = '{0, 0, 32'h106, '0, 16'h0000, 6};
    tbl[8] = '{1, 0, 32'h100, '0, 16'h0000, 8};
    tbl[9] = '{1, 0, 32'h300, '0, 16'h0000, 8};

    for (int i = 0; i < 512; i++) refm[i] = init_word(i);
    lr[0] = '0;
    lr[1] = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_rdata1", rdb1, 128'h0);
    chk("rst_rdata3", rdb3, 128'h0);
    chk("rst_ready1", 128'(dr1), 128'h0);
    chk("rst_ready3", 128'(dr3), 128'h0);
    chk("rst_cs1", 128'(cs1), 128'h0);
    chk("rst_cs3", 128'(cs3), 128'h0);
    chk("rst_addr1", 128'(ma1), 128'h0);
    chk("rst_be1", 128'(mbe1), 128'h0);
    chk("rst_wd1", 128'(mwd1), 128'h0);
    chk("rst_we1", 128'(we1), 128'h0);
    async_reset = 1'b0;

    foreach (tbl[i])
      do_req(tbl[i].s, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].lat, 0, 0, 0);

    do_req(0, 0, 32'h200, '0, 16'h0000, 6, 1, 1, 0);
    do_req(0, 1, 32'h3FFF_FFFC,
           {32'hE3E3_E3E3, 32'hE2E2_E2E2, 32'hE1E1_E1E1, 32'hE0E0_E0E0},
           16'hFFFF, 5, 1, 1, 0);
    do_req(0, 0, 32'h3FFF_FFFC, '0, 16'h0000, 6, 0, 0, 0);

    do_req(0, 0, 32'h300, '0, 16'h0000, 6, 0, 0, 1);
    do_req(0, 1, 32'h200, {4{32'h0BAD_F00D}}, 16'hF0F0, 5, 0, 0, 1);

    @(posedge clock);
    @(negedge clock);
    sel = 1'b0;
    mem_write = 1'b0;
    address = 32'h100;
    byte_enablers = 16'h0000;
    mt1 = 1'b1;
    push_req(0, 32'h100, '0, 16'h0000, 6);
    void'(rq.pop_back());
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
    end
    mt1 = 1'b0;
    chk("pre_reset_ready", 128'(dr1), 128'h0);
    #1 async_reset = 1'b1;
    #1;
    chk("mid_rst_cs", 128'(cs1), 128'h0);
    chk("mid_rst_we", 128'(we1), 128'h0);
    chk("mid_rst_addr", 128'(ma1), 128'h0);
    chk("mid_rst_be", 128'(mbe1), 128'h0);
    chk("mid_rst_wd", 128'(mwd1), 128'h0);
    chk("mid_rst_rdata", rdb1, 128'h0);
    chk("mid_rst_ready", 128'(dr1), 128'h0);
    lr[0] = '0;
    lr[1] = '0;
    @(negedge clock);
    async_reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("post_rst_no_ready", 128'(dr1), 128'h0);
    end
    do_req(0, 0, 32'h100, '0, 16'h0000, 6, 0, 0, 0);

    repeat (3) @(negedge clock);
    chk("ready_pulses", 128'(drn), 128'(ndone));
    chk("beats_left", 128'(bq.size()), 128'h0);
    chk("results_left", 128'(rq.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
